// File: rtl/dsp24_mac_seq.sv
// Sequencer that drives one DSP24 as a signed 8x8 multiply-accumulator.
// Streams LEN operand pairs in, drains the DSP pipeline and hands out the 24-bit sum.
module dsp24_mac_seq #(
    parameter int LEN   = 16,
    parameter int PIPE  = 0,
    parameter int CNT_W = 16
) (
    input  logic              CLK,
    input  logic              a_RST,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_a,
    input  logic [7:0]        s_b,
    input  logic              s_sub,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [23:0]       m_data,
    output logic [7:0]        dsp_a,
    output logic [7:0]        dsp_b,
    output logic [1:0]        dsp_op,
    output logic              dsp_ce,
    output logic              dsp_rst,
    input  logic [23:0]       dsp_w,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST       = CNT_W'(LEN - 1);
    localparam logic [CNT_W-1:0] LP_DRAIN_LAST = CNT_W'((PIPE > 0) ? (PIPE - 1) : 0);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dsp_rst;
    logic             r_m_valid;
    logic [23:0]      r_m_data;
    logic             w_accept;

    // Next-state decode and the combinational DSP pin drive for the current state.
    always_comb begin
        w_next   = r_state;
        s_ready  = 1'b0;
        dsp_a    = 8'd0;
        dsp_b    = 8'd0;
        dsp_op   = 2'b00;
        dsp_ce   = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next = S_CLR;
            end
            S_CLR: begin
                w_next = S_RUN;
            end
            S_RUN: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    dsp_a    = s_a;
                    dsp_b    = s_b;
                    dsp_op   = s_sub ? 2'b10 : 2'b00;
                    dsp_ce   = 1'b1;
                    w_accept = 1'b1;
                    if (r_cnt == LP_LAST) begin
                        w_next = (PIPE > 0) ? S_DRAIN : S_DONE;
                    end else begin
                        w_next = S_RUN;
                    end
                end else begin
                    // Stall: CE low freezes every DSP register, so nothing is lost.
                    dsp_ce = 1'b0;
                    w_next = S_RUN;
                end
            end
            S_DRAIN: begin
                dsp_ce = 1'b1;
                if (r_cnt == LP_DRAIN_LAST) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_DRAIN;
                end
            end
            S_DONE: begin
                w_next = S_OUT;
            end
            S_OUT: begin
                if (m_ready) begin
                    w_next = S_CLR;
                end else begin
                    w_next = S_OUT;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge a_RST) begin
        if (a_RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Shared counter: products accepted in RUN, then drain cycles in DRAIN.
    always_ff @(posedge CLK or posedge a_RST) begin
        if (a_RST) begin
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_accept) begin
                        r_cnt <= (r_cnt == LP_LAST) ? {CNT_W{1'b0}} : (r_cnt + CNT_W'(1));
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                S_DRAIN: begin
                    r_cnt <= (r_cnt == LP_DRAIN_LAST) ? {CNT_W{1'b0}} : (r_cnt + CNT_W'(1));
                end
                default: begin
                    r_cnt <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // DSP reset is registered off the next state so it is high exactly during CLR.
    always_ff @(posedge CLK or posedge a_RST) begin
        if (a_RST) begin
            r_dsp_rst <= 1'b0;
        end else begin
            r_dsp_rst <= (w_next == S_CLR);
        end
    end

    // Result capture and output handshake.
    always_ff @(posedge CLK or posedge a_RST) begin
        if (a_RST) begin
            r_m_valid <= 1'b0;
            r_m_data  <= 24'd0;
        end else if (r_state == S_DONE) begin
            r_m_valid <= 1'b1;
            r_m_data  <= dsp_w;
        end else if ((r_state == S_OUT) && m_ready) begin
            r_m_valid <= 1'b0;
            r_m_data  <= r_m_data;
        end else begin
            r_m_valid <= r_m_valid;
            r_m_data  <= r_m_data;
        end
    end

    assign dsp_rst = r_dsp_rst;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_dsp24_mac_seq.sv
// Bench for dsp24_mac_seq: two instances (LEN=4/PIPE=0 and LEN=2/PIPE=2), each wired to a
// behavioural DSP24 model, checked against a plain-arithmetic dot-product reference.
module tb_dsp24_mac_seq;

    logic CLK = 1'b0;
    logic a_RST;
    always #5 CLK = ~CLK;

    // Instance 0: LEN=4, PIPE=0
    logic        v0, rdy0, sub0, mv0, mr0, ce0, rst0, busy0;
    logic [7:0]  a0, b0, dsp_a0, dsp_b0;
    logic [1:0]  dsp_op0;
    logic [23:0] md0, w0;

    // Instance 2: LEN=2, PIPE=2
    logic        v2, rdy2, sub2, mv2, mr2, ce2, rst2, busy2;
    logic [7:0]  a2, b2, dsp_a2, dsp_b2;
    logic [1:0]  dsp_op2;
    logic [23:0] md2, w2;

    dsp24_mac_seq #(.LEN(4), .PIPE(0), .CNT_W(16)) u_dut0 (
        .CLK(CLK), .a_RST(a_RST), .s_valid(v0), .s_ready(rdy0), .s_a(a0), .s_b(b0),
        .s_sub(sub0), .m_valid(mv0), .m_ready(mr0), .m_data(md0), .dsp_a(dsp_a0),
        .dsp_b(dsp_b0), .dsp_op(dsp_op0), .dsp_ce(ce0), .dsp_rst(rst0), .dsp_w(w0),
        .busy(busy0)
    );

    dsp24_mac_seq #(.LEN(2), .PIPE(2), .CNT_W(16)) u_dut2 (
        .CLK(CLK), .a_RST(a_RST), .s_valid(v2), .s_ready(rdy2), .s_a(a2), .s_b(b2),
        .s_sub(sub2), .m_valid(mv2), .m_ready(mr2), .m_data(md2), .dsp_a(dsp_a2),
        .dsp_b(dsp_b2), .dsp_op(dsp_op2), .dsp_ce(ce2), .dsp_rst(rst2), .dsp_w(w2),
        .busy(busy2)
    );

    // DSP24 model, no input/product registers: W accumulates the product directly.
    logic signed [15:0] p0;
    logic [23:0]        w0r;
    assign p0 = $signed(dsp_a0) * $signed(dsp_b0);
    assign w0 = w0r;
    always @(posedge CLK) begin
        if (rst0)     w0r <= 24'd0;
        else if (ce0) w0r <= dsp_op0[1] ? (w0r - {{8{p0[15]}}, p0}) : (w0r + {{8{p0[15]}}, p0});
    end

    // DSP24 model with A/B registers and a P register ahead of W; OP is not registered.
    logic signed [7:0]  ar2, br2;
    logic signed [15:0] pr2;
    logic [23:0]        w2r;
    assign w2 = w2r;
    always @(posedge CLK) begin
        if (rst2) begin
            ar2 <= 8'sd0; br2 <= 8'sd0; pr2 <= 16'sd0; w2r <= 24'd0;
        end else if (ce2) begin
            ar2 <= $signed(dsp_a2);
            br2 <= $signed(dsp_b2);
            pr2 <= ar2 * br2;
            w2r <= dsp_op2[1] ? (w2r - {{8{pr2[15]}}, pr2}) : (w2r + {{8{pr2[15]}}, pr2});
        end
    end

    // Accepted-transfer counter for instance 0.
    int acc0 = 0;
    always @(posedge CLK) begin
        if (v0 && rdy0) acc0 <= acc0 + 1;
    end

    int n_err = 0;
    int n_chk = 0;
    int exp0;
    int exp2;
    int lat;
    int acc_snap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Offer one pair to instance 0 and hold it until accepted; updates the reference sum.
    task automatic send0(input int a, input int b, input bit s);
        bit got;
        got = 1'b0;
        @(negedge CLK);
        a0 = 8'(a); b0 = 8'(b); sub0 = s; v0 = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            #1;
            if (rdy0) begin
                chk("op_on_accept", {30'd0, dsp_op0}, s ? 32'd2 : 32'd0);
                exp0 = s ? (exp0 - a * b) : (exp0 + a * b);
                got = 1'b1;
                @(posedge CLK);
                #1;
                v0 = 1'b0;
            end else begin
                @(negedge CLK);
            end
        end
        if (!got) begin
            chk("send_timeout", 32'd0, 32'd1);
            v0 = 1'b0;
        end
    endtask

    // Count falling edges from the last accept until m_valid rises (bounded).
    task automatic wait_mv0(output int l);
        l = 0;
        while (!mv0 && l < 40) begin
            @(negedge CLK);
            l++;
        end
    endtask

    initial begin
        logic [7:0] ra, rb;
        int         pat [7];
        int         d;
        pat = '{1, 0, 0, 1, 0, 1, 1};
        a_RST = 1'b1;
        v0 = 1'b0; a0 = 8'd0; b0 = 8'd0; sub0 = 1'b0; mr0 = 1'b1;
        v2 = 1'b0; a2 = 8'd0; b2 = 8'd0; sub2 = 1'b0; mr2 = 1'b1;
        exp0 = 0; exp2 = 0;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_m_valid", {31'd0, mv0}, 32'd0);
        chk("rst_m_data", {8'd0, md0}, 32'd0);
        chk("rst_dsp_rst", {31'd0, rst0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_s_ready", {31'd0, rdy0}, 32'd0);
        a_RST = 1'b0;
        @(negedge CLK);
        chk("clr_pulse", {31'd0, rst0}, 32'd1);
        chk("clr_ce", {31'd0, ce0}, 32'd0);

        // Basic dot product, back to back
        exp0 = 0;
        send0(3, 5, 1'b0); send0(-2, 7, 1'b0); send0(10, 10, 1'b0); send0(-1, -1, 1'b0);
        wait_mv0(lat);
        chk("t1_latency", 32'(lat), 32'd2);
        chk("t1_data", {8'd0, md0}, 32'h000066);
        chk("t1_ref", {8'd0, md0}, {8'd0, 24'(exp0)});
        @(negedge CLK);
        chk("t1_mv_cleared", {31'd0, mv0}, 32'd0);
        chk("t1_clr_after", {31'd0, rst0}, 32'd1);

        // Mixed add/subtract
        exp0 = 0;
        send0(100, 100, 1'b0); send0(50, 2, 1'b1); send0(-128, -128, 1'b0); send0(1, 1, 1'b1);
        wait_mv0(lat);
        chk("t2_data", {8'd0, md0}, 32'h0066AB);
        chk("t2_ref", {8'd0, md0}, {8'd0, 24'(exp0)});
        @(negedge CLK);
        chk("t2_clr_after", {31'd0, rst0}, 32'd1);

        // s_valid gaps, then hold m_ready low in OUT
        mr0 = 1'b0;
        acc_snap = acc0;
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            v0 = pat[i][0]; a0 = 8'd2; b0 = 8'd3; sub0 = 1'b0;
            #1;
            chk("gap_ce", {31'd0, ce0}, 32'(pat[i]));
        end
        @(posedge CLK);
        #1;
        v0 = 1'b0;
        wait_mv0(lat);
        chk("gap_accepts", 32'(acc0 - acc_snap), 32'd4);
        chk("gap_data", {8'd0, md0}, 32'd24);
        v0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("hold_valid", {31'd0, mv0}, 32'd1);
            chk("hold_data", {8'd0, md0}, 32'd24);
            chk("hold_s_ready", {31'd0, rdy0}, 32'd0);
            chk("hold_ce", {31'd0, ce0}, 32'd0);
        end
        v0 = 1'b0;
        mr0 = 1'b1;
        @(negedge CLK);
        chk("hold_release_mv", {31'd0, mv0}, 32'd0);
        chk("hold_release_rst", {31'd0, rst0}, 32'd1);
        chk("hold_no_extra_accept", 32'(acc0 - acc_snap), 32'd4);

        // PIPE=2, LEN=2 instance: drain cycles and longer latency
        exp2 = 127 * 127 * 2;
        for (int k = 0; k < 2; k++) begin
            bit got;
            got = 1'b0;
            @(negedge CLK);
            v2 = 1'b1; a2 = 8'd127; b2 = 8'd127; sub2 = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                #1;
                if (rdy2) begin
                    got = 1'b1;
                    @(posedge CLK);
                    #1;
                    v2 = 1'b0;
                end else begin
                    @(negedge CLK);
                end
            end
            if (!got) chk("p2_send_timeout", 32'd0, 32'd1);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk("p2_drain_ce", {31'd0, ce2}, 32'd1);
            chk("p2_drain_ops", {16'd0, dsp_a2, dsp_b2}, 32'd0);
            chk("p2_drain_mv", {31'd0, mv2}, 32'd0);
        end
        @(negedge CLK);
        chk("p2_done_mv", {31'd0, mv2}, 32'd0);
        @(negedge CLK);
        chk("p2_mv_lat3", {31'd0, mv2}, 32'd1);
        chk("p2_data", {8'd0, md2}, {8'd0, 24'(exp2)});
        chk("p2_busy", {31'd0, busy2}, 32'd1);

        // Randomized dot products with random gaps and random m_ready delay
        for (int k = 0; k < 4; k++) begin
            exp0 = 0;
            mr0 = 1'b0;
            for (int j = 0; j < 4; j++) begin
                repeat ($urandom_range(0, 2)) @(negedge CLK);
                ra = 8'($urandom);
                rb = 8'($urandom);
                send0(int'($signed(ra)), int'($signed(rb)), 1'($urandom));
            end
            wait_mv0(lat);
            chk("rnd_latency", 32'(lat), 32'd2);
            chk("rnd_data", {8'd0, md0}, {8'd0, 24'(exp0)});
            d = $urandom_range(0, 3);
            repeat (d) @(negedge CLK);
            chk("rnd_data_stable", {8'd0, md0}, {8'd0, 24'(exp0)});
            mr0 = 1'b1;
            @(negedge CLK);
            chk("rnd_mv_cleared", {31'd0, mv0}, 32'd0);
        end

        // Asynchronous reset in the middle of RUN
        exp0 = 0;
        send0(1, 1, 1'b0); send0(1, 1, 1'b0);
        a_RST = 1'b1;
        #1;
        chk("arst_m_valid", {31'd0, mv0}, 32'd0);
        chk("arst_s_ready", {31'd0, rdy0}, 32'd0);
        chk("arst_busy", {31'd0, busy0}, 32'd0);
        @(negedge CLK);
        a_RST = 1'b0;
        #1;
        chk("arst_idle", {31'd0, busy0}, 32'd0);
        @(negedge CLK);
        chk("arst_clr", {31'd0, rst0}, 32'd1);
        exp0 = 0;
        for (int j = 0; j < 4; j++) send0(1, 1, 1'b0);
        wait_mv0(lat);
        chk("arst_fresh_data", {8'd0, md0}, 32'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dsp24_mac_seq.md
Name: dsp24_mac_seq

Overview:
- Upstream sequencer for one DSP24 primitive configured as a multiply-accumulator.
- Accepts a valid/ready stream of signed 8-bit operand pairs and drives the DSP A/B/OP/CE/RST pins for LEN products per dot product.
- Waits out the DSP pipeline, captures the 24-bit accumulator and presents it on a valid/ready result port.
- Required DSP24 configuration: SIGNED=1, RST_SYNC=1, M_SEL="P", N_SEL="W", W_REG=1, OP_REG=0, C_REG=0, O_REG=0, SHIFTER=0, all *_USE_CE=1, all *_USE_RST=1. A_REG, B_REG and P_REG are free; PIPE must equal A_REG + P_REG (with B_REG = A_REG).

Parameters:
- LEN, 16: products per dot product, must be 1..65535.
- PIPE, 0: number of enabled DSP stages ahead of W (0..2).
- CNT_W, 16: width of the product counter, must satisfy 2^CNT_W > LEN.

Ports:
- CLK  in  1  clock, rising edge.
- a_RST  in  1  reset, asynchronous, active-high.
- s_valid  in  1  operand pair valid.
- s_ready  out  1  operand pair accepted when high together with s_valid.
- s_a  in  8  signed multiplicand.
- s_b  in  8  signed multiplier.
- s_sub  in  1  1 = subtract this product, 0 = add it.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- m_data  out  24  signed dot-product result, wraps mod 2^24.
- dsp_a  out  8  to DSP24 A.
- dsp_b  out  8  to DSP24 B.
- dsp_op  out  2  to DSP24 OP.
- dsp_ce  out  1  to DSP24 CE.
- dsp_rst  out  1  to DSP24 RST (synchronous inside the DSP).
- dsp_w  in  24  from DSP24 CASCOUT with CASCOUT_SEL="W".
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (a_RST high, asynchronous): state=IDLE, cnt=0, m_valid=0, m_data=0, dsp_rst=0; combinational outputs follow the IDLE state.
- FSM states and transitions:
  - IDLE -> CLR unconditionally on the next edge.
  - CLR, 1 cycle: dsp_rst=1, dsp_ce=0, which zeroes W. CLR -> RUN.
  - RUN: s_ready=1.
    - When s_valid=1: dsp_a=s_a, dsp_b=s_b, dsp_op = s_sub ? 2'b10 : 2'b00, dsp_ce=1, cnt increments.
    - When s_valid=0: dsp_ce=0 and dsp_a/dsp_b/dsp_op=0, so the DSP holds all registers and stalls are lossless.
    - The accept with cnt==LEN-1 moves the FSM to DRAIN if PIPE>0, otherwise to DONE; cnt resets to 0.
  - DRAIN: dsp_a=dsp_b=0, dsp_op=0, dsp_ce=1, which adds zero products. Lasts exactly PIPE cycles, then -> DONE.
  - DONE, 1 cycle: m_data<=dsp_w, m_valid<=1. DONE -> OUT.
  - OUT: m_valid=1 and m_data is held stable. When m_ready=1 -> CLR with m_valid cleared on that edge. s_ready=0 while in OUT.
- dsp_op values: 2'b00 gives W+P; 2'b10 gives W-P (-M+N).
- Outside RUN, s_ready=0. dsp_rst is registered and is high only in CLR.
- Latency: last accept to m_valid=1 is PIPE+1 cycles. Minimum dot-product period is LEN+3+PIPE cycles with no stalls.
- Arithmetic:
  - Products are 16-bit signed, sign-extended to 24 bits.
  - The sum wraps modulo 2^24; no saturation and no overflow flag.
- Boundary conditions:
  - LEN=1: a single accept leaves RUN.
  - m_ready is ignored outside OUT.
  - m_ready=1 already high on entry to OUT: handshake completes in the first OUT cycle.
  - s_valid high in CLR/DRAIN/DONE/OUT: not accepted, no DSP activity.
  - a_RST asserted mid-RUN or mid-DRAIN: the partial sum is discarded, m_valid=0 immediately, and the next sequence starts from IDLE -> CLR, which clears the DSP.

Test Plan:
- LEN=4, PIPE=0; pairs (3,5,+), (-2,7,+), (10,10,+), (-1,-1,+) back-to-back, m_ready=1 -> m_data=24'h000066 (102), m_valid 1 cycle after last accept, then CLR pulse on dsp_rst.
- LEN=4; pairs (100,100,+), (50,2,-), (-128,-128,+), (1,1,-) -> m_data=10000-100+16384-1=26283=24'h0066AB; dsp_op=2'b10 on the two subtract accepts.
- LEN=4; s_valid toggled 1,0,0,1,0,1,1 with pairs all (2,3,+) -> dsp_ce low on every gap, m_data=24, exactly 4 accepts counted.
- PIPE=2, LEN=2; pairs (127,127,+), (127,127,+) -> two DRAIN cycles with dsp_ce=1 and zero operands, m_data=32258, m_valid 3 cycles after last accept.
- Hold m_ready=0 for 5 cycles in OUT -> m_data/m_valid stable, s_ready=0; release -> one transfer, dsp_rst=1 on next cycle.
- Assert a_RST after 2 of 4 accepts -> m_valid=0, s_ready=0 at once; after release, IDLE, CLR, then a fresh (1,1,+)x4 gives m_data=4.
